// File: rtl/mem_copy_master_if.sv
// ----------------------------------------------------------------------------
// mem_copy_master_if
//  Bus between the copy engine (master) and a single-port word RAM (slave).
//  The RAM returns read data combinationally while o_read is high and commits
//  a write on the rising edge where o_write is high. The strobes are exclusive.
//
//  o_addr   master->slave  word address
//  o_data   master->slave  write data
//  o_read   master->slave  read strobe
//  o_write  master->slave  write strobe
//  i_rdata  slave->master  read data (combinational)
// ----------------------------------------------------------------------------
interface mem_copy_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0] o_addr;
   logic [DATA_WIDTH-1:0] o_data;
   logic                  o_read;
   logic                  o_write;
   logic [DATA_WIDTH-1:0] i_rdata;

   modport master (
      output o_addr, o_data, o_read, o_write,
      input  i_rdata
   );

   modport slave (
      input  o_addr, o_data, o_read, o_write,
      output i_rdata
   );
endinterface

// File: rtl/mem_copy_master.sv
// ----------------------------------------------------------------------------
// mem_copy_master
//  Small DMA engine that copies i_len words from i_src to i_dst over a
//  single-port RAM, one word per read/write cycle pair, strictly ascending.
//
//  i_clk, i_rst_n          clock, asynchronous active-low reset
//  i_start                 start request, honoured only when idle
//  i_abort                 stop request, honoured in READ/WRITE
//  i_src, i_dst, i_len     transfer operands, latched at start
//  bus (master)            RAM address/data/strobes and read data
//  o_busy                  high while a transfer (or its done cycle) is active
//  o_done                  one-cycle pulse on normal completion
//  o_count                 words written in the current/last transfer
// ----------------------------------------------------------------------------
module mem_copy_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic                  i_abort,
   input  logic [ADDR_WIDTH-1:0] i_src,
   input  logic [ADDR_WIDTH-1:0] i_dst,
   input  logic [LEN_WIDTH-1:0]  i_len,
   mem_copy_master_if.master     bus,
   output logic                  o_busy,
   output logic                  o_done,
   output logic [LEN_WIDTH-1:0]  o_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] src_q;
   logic [ADDR_WIDTH-1:0] dst_q;
   logic [LEN_WIDTH-1:0]  len_q;
   // Word index; it is also the count of words written, so it drives o_count.
   logic [LEN_WIDTH-1:0]  k_q;
   // Word captured in READ; it is presented as write data in WRITE and held in IDLE.
   logic [DATA_WIDTH-1:0] buf_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  read_q;
   logic                  write_q;
   logic                  busy_q;
   logic                  done_q;

   // One bit wider than the index so k+1 < len can never wrap.
   logic [LEN_WIDTH:0]    k_nxt_d;
   logic                  more_d;
   logic [ADDR_WIDTH-1:0] rd_addr_d;
   logic [ADDR_WIDTH-1:0] wr_addr_d;

   always_comb begin
      k_nxt_d   = {1'b0, k_q} + {{LEN_WIDTH{1'b0}}, 1'b1};
      more_d    = k_nxt_d < {1'b0, len_q};
      // Address arithmetic wraps modulo 2^ADDR_WIDTH by truncation.
      rd_addr_d = src_q + ADDR_WIDTH'(k_nxt_d);
      wr_addr_d = dst_q + ADDR_WIDTH'(k_q);
   end

   // All outputs are registered and are set up one edge ahead for the state
   // being entered. Because of this, an asynchronous reset drops the strobes
   // at once, and o_addr/o_data keep their last value while idle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= S_IDLE;
         src_q   <= '0;
         dst_q   <= '0;
         len_q   <= '0;
         k_q     <= '0;
         buf_q   <= '0;
         addr_q  <= '0;
         read_q  <= 1'b0;
         write_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // When start and abort arrive together, start wins: abort is not looked at here.
               if (i_start) begin
                  src_q  <= i_src;
                  dst_q  <= i_dst;
                  len_q  <= i_len;
                  k_q    <= '0;
                  busy_q <= 1'b1;
                  if (i_len != '0) begin
                     state_q <= S_READ;
                     read_q  <= 1'b1;
                     addr_q  <= i_src;
                  end else begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end
               end
            end
            S_READ: begin
               read_q <= 1'b0;
               if (i_abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  buf_q   <= bus.i_rdata;
                  write_q <= 1'b1;
                  addr_q  <= wr_addr_d;
                  state_q <= S_WRITE;
               end
            end
            S_WRITE: begin
               // The RAM commits on this edge regardless of abort, so the word counts.
               write_q <= 1'b0;
               k_q     <= k_nxt_d[LEN_WIDTH-1:0];
               if (i_abort) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
               end else if (more_d) begin
                  state_q <= S_READ;
                  read_q  <= 1'b1;
                  addr_q  <= rd_addr_d;
               end else begin
                  state_q <= S_DONE;
                  done_q  <= 1'b1;
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               read_q  <= 1'b0;
               write_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.o_addr  = addr_q;
   assign bus.o_data  = buf_q;
   assign bus.o_read  = read_q;
   assign bus.o_write = write_q;
   assign o_busy      = busy_q;
   assign o_done      = done_q;
   assign o_count     = k_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// ----------------------------------------------------------------------------
// tb_mem_copy_master
//  Directed bench for mem_copy_master with a 32-word RAM (ADDR_WIDTH=5).
//  Stimulus pushes the expected bus events (read addr, write addr/data,
//  done with count) into a queue, and a negedge monitor pops and compares them.
//  A shadow RAM holds the expected memory image.
// ----------------------------------------------------------------------------
module tb_mem_copy_master;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int LW = 16;

   logic          clk   = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic          abort = 1'b0;
   logic [AW-1:0] src   = '0;
   logic [AW-1:0] dst   = '0;
   logic [LW-1:0] len   = '0;
   logic          busy;
   logic          done;
   logic [LW-1:0] count;

   mem_copy_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mem_copy_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_start (start),
      .i_abort (abort),
      .i_src   (src),
      .i_dst   (dst),
      .i_len   (len),
      .bus     (bus),
      .o_busy  (busy),
      .o_done  (done),
      .o_count (count)
   );

   always #5 clk = ~clk;

   // RAM model: combinational read, write on rising edge, plus a preload port.
   logic [DW-1:0] ram    [32];
   logic [DW-1:0] shadow [32];
   logic          ld_en   = 1'b0;
   logic [AW-1:0] ld_addr = '0;
   logic [DW-1:0] ld_data = '0;

   always @(posedge clk) begin
      if (ld_en) ram[ld_addr] <= ld_data;
      else if (bus.o_write) ram[bus.o_addr] <= bus.o_data;
   end
   assign bus.i_rdata = bus.o_read ? ram[bus.o_addr] : '0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int            kind;   // 0 read, 1 write, 2 done
      logic [AW-1:0] addr;
      logic [DW-1:0] data;   // write data, or count for done
   } ev_t;
   ev_t expq[$];

   function automatic void push(int k, logic [AW-1:0] a, logic [DW-1:0] d);
      ev_t e;
      e.kind = k; e.addr = a; e.data = d;
      expq.push_back(e);
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every cycle that has a strobe or done must match the next expected event.
   always @(negedge clk) begin
      ev_t           e;
      int            k;
      logic [DW-1:0] d;
      if (rst_n) begin
         if (bus.o_read && bus.o_write) begin
            checks++; errors++;
            $display("FAIL strobes: read and write both high at addr %0d", bus.o_addr);
         end else if (bus.o_read || bus.o_write || done) begin
            k = done ? 2 : (bus.o_write ? 1 : 0);
            d = done ? DW'(count) : (bus.o_write ? bus.o_data : '0);
            checks++;
            if (expq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_event: kind %0d addr %0d data %0h, none expected", k, bus.o_addr, d);
            end else begin
               e = expq.pop_front();
               if (e.kind != k || (k != 2 && e.addr !== bus.o_addr) || e.data !== d) begin
                  errors++;
                  $display("FAIL bus_event: got kind %0d addr %0d data %0h expected kind %0d addr %0d data %0h",
                           k, bus.o_addr, d, e.kind, e.addr, e.data);
               end
            end
         end
      end
   end

   task automatic poke(int a, logic [DW-1:0] d);
      ld_en   = 1'b1;
      ld_addr = AW'(a);
      ld_data = d;
      shadow[a] = d;
      @(posedge clk); #1;
      ld_en = 1'b0;
   endtask

   // abort_at / restart_at: cycle number (start sampled at cycle 0), -1 for none.
   task automatic xfer(string name, int s, int d, int n, int abort_at, int restart_at);
      int            words, done_cyc, idle_cyc, mism;
      logic [AW-1:0] ra, wa;
      logic [DW-1:0] v;
      // Write of word j is cycle 2j+2, read is 2j+1: both give floor(abort_at/2) words.
      words = (abort_at > 0) ? abort_at / 2 : n;
      for (int j = 0; j < words; j++) begin
         ra = AW'(s + j);
         wa = AW'(d + j);
         v  = shadow[ra];
         push(0, ra, '0);
         push(1, wa, v);
         shadow[wa] = v;
      end
      if (abort_at > 0 && (abort_at % 2) == 1) push(0, AW'(s + words), '0);
      if (abort_at < 0) push(2, '0, DW'(n));

      src = AW'(s); dst = AW'(d); len = LW'(n); start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      done_cyc = -1; idle_cyc = -1;
      for (int c = 1; c <= 2 * n + 4; c++) begin
         if (done && done_cyc < 0) done_cyc = c;
         if (!busy && idle_cyc < 0) idle_cyc = c;
         if (c == abort_at) abort = 1'b1;
         if (c == restart_at) begin start = 1'b1; src = AW'(20); end
         @(posedge clk); #1;
         abort = 1'b0; start = 1'b0;
      end

      if (abort_at < 0) begin
         chk({name, "_done_cycle"}, 64'(done_cyc), 64'(2 * n + 1));
         chk({name, "_idle_cycle"}, 64'(idle_cyc), 64'(2 * n + 2));
      end else begin
         chk({name, "_no_done"}, 64'(done_cyc), 64'(-1));
         chk({name, "_idle_cycle"}, 64'(idle_cyc), 64'(abort_at + 1));
      end
      chk({name, "_count"}, 64'(count), 64'(words));
      chk({name, "_events_left"}, 64'(expq.size()), 64'(0));
      mism = 0;
      for (int i = 0; i < 32; i++) if (ram[i] !== shadow[i]) mism++;
      chk({name, "_ram_mismatches"}, 64'(mism), 64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 32; i++) poke(i, DW'(32'h100 + i * 3));
      poke(0, 2); poke(1, 5); poke(2, 1);
      poke(30, 32'hAA); poke(31, 32'hBB);

      chk("reset_outputs", 64'({busy, done, count, bus.o_read, bus.o_write, bus.o_addr, bus.o_data}), 64'(0));
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Basic copy 0..2 -> 8..10, done at cycle 7.
      xfer("basic", 0, 8, 3, -1, -1);
      chk("basic_ram8", 64'(ram[8]), 64'(2));
      chk("basic_ram9", 64'(ram[9]), 64'(5));
      chk("basic_ram10", 64'(ram[10]), 64'(1));

      // Zero length: only a done pulse at cycle 1.
      xfer("len0", 3, 12, 0, -1, -1);

      // Start pulsed again mid-transfer with another source: ignored.
      xfer("restart", 0, 12, 3, -1, 3);
      chk("restart_ram12", 64'(ram[12]), 64'(2));
      chk("restart_ram14", 64'(ram[14]), 64'(1));

      // Source wraps 30,31,0.
      xfer("wrap", 30, 4, 3, -1, -1);
      chk("wrap_ram4", 64'(ram[4]), 64'(32'hAA));
      chk("wrap_ram5", 64'(ram[5]), 64'(32'hBB));
      chk("wrap_ram6", 64'(ram[6]), 64'(2));

      // Abort in the WRITE of word 1: two words copied, no done.
      xfer("abort_wr", 0, 16, 4, 4, -1);
      chk("abort_wr_ram17", 64'(ram[17]), 64'(5));
      chk("abort_wr_ram18", 64'(ram[18]), 64'(32'h100 + 18 * 3));

      // Abort in the READ of word 1: one word copied.
      xfer("abort_rd", 0, 24, 4, 3, -1);
      chk("abort_rd_ram25", 64'(ram[25]), 64'(32'h100 + 25 * 3));

      // Overlap with dst>src propagates the first word forward.
      xfer("overlap", 0, 1, 3, -1, -1);
      chk("overlap_ram3", 64'(ram[3]), 64'(2));

      // Reset while o_write is high: outputs clear at once, no commit.
      push(0, AW'(0), '0);
      src = 0; dst = 20; len = 3; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      chk("rst_pre_write", 64'(bus.o_write), 64'(1));
      #1 rst_n = 1'b0;
      #1 chk("rst_async_outputs", 64'({busy, done, count, bus.o_read, bus.o_write}), 64'(0));
      chk("rst_events_left", 64'(expq.size()), 64'(0));
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("rst_no_commit", 64'(ram[20]), 64'(shadow[20]));

      // Engine is usable again after reset.
      xfer("post_reset", 8, 28, 2, -1, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
